// File: rtl/pl_if_stage.sv
// pl_if_stage: instruction fetch stage owning the PC and the IF/ID pipeline register
module pl_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d, fetch_count_q, fetch_count_d;
  logic        ifid_valid_q, ifid_valid_d, adv;
  // next state: redirect beats stall, a plain fetch advances everything
  always_comb begin
    adv           = !redirect && !stall;
    pc_d          = redirect ? {redirect_pc[31:2], 2'b00} : adv ? pc_q + 32'd4 : pc_q;
    ifid_pc_d     = adv ? pc_q : ifid_pc_q;
    ifid_pc4_d    = adv ? pc_q + 32'd4 : ifid_pc4_q;
    ifid_instr_d  = redirect ? NOP_INSTR : adv ? imem_rdata : ifid_instr_q;
    ifid_valid_d  = redirect ? 1'b0 : adv ? 1'b1 : ifid_valid_q;
    fetch_count_d = adv ? fetch_count_q + 32'd1 : fetch_count_q;
  end
  // state registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= 32'd0;
      ifid_pc4_q    <= 32'd4;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_pl_if_stage.sv
// tb_pl_if_stage: directed plus randomized check of the fetch stage against a behavioural model
module tb_pl_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0;
  logic        rst = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_pc4, ifid_instr, fetch_count;
  logic        ifid_valid;
  logic        rst_w = 1;
  logic [31:0] w_addr, w_rdata, w_pc, w_pc4, w_instr, w_cnt;
  logic        w_valid;
  logic [31:0] mem [64];
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_ipc, m_cnt;
  logic        m_v;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];
  assign w_rdata    = mem[w_addr[7:2]];

  pl_if_stage u_dut (
    .clk(clk), .rstn(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .fetch_count(fetch_count)
  );

  pl_if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rstn(rst_w), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .ifid_valid(w_valid),
    .ifid_pc(w_pc), .ifid_pc4(w_pc4), .ifid_instr(w_instr), .fetch_count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // IF/ID content is fully determined by which address (if any) it holds
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'd0; m_v = 0; m_ipc = 32'd0; m_cnt = 0;
    end else if (rd) begin
      m_pc = rpc & ~32'd3; m_v = 0;
    end else if (!s) begin
      m_ipc = m_pc; m_v = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc4", ifid_pc4, m_ipc + 4);
    chk("ifid_instr", ifid_instr, m_v ? mem[m_ipc[7:2]] : NOP);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113; mem[2] = 32'h0020_81B3;
    m_pc = 0; m_ipc = 0; m_cnt = 0; m_v = 0;
    #2;
    step(1, 0, 0, 0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_pc4", ifid_pc4, 32'd4);
    chk("rst_instr", ifid_instr, NOP);
    step(0, 0, 0, 0);
    chk("seq_instr0", ifid_instr, 32'h0050_0093);
    chk("seq_valid0", {31'd0, ifid_valid}, 32'd1);
    step(0, 0, 0, 0);
    chk("seq_addr8", imem_addr, 32'd8);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_pc", imem_addr, 32'd8);
    chk("stall_ifid_pc", ifid_pc, 32'd4);
    chk("stall_cnt", fetch_count, 32'd2);
    step(0, 0, 0, 0);
    chk("resume_ifid_pc", ifid_pc, 32'd8);
    chk("resume_pc", imem_addr, 32'd12);
    chk("resume_instr", ifid_instr, 32'h0020_81B3);
    chk("resume_cnt", fetch_count, 32'd3);
    step(0, 0, 1, 32'h40);
    chk("redir_pc", imem_addr, 32'h40);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_instr", ifid_instr, NOP);
    step(0, 0, 0, 0);
    chk("redir_ifid_pc", ifid_pc, 32'h40);
    chk("redir_valid1", {31'd0, ifid_valid}, 32'd1);
    step(0, 0, 1, 32'h43);
    chk("misalign_pc", imem_addr, 32'h40);
    step(0, 1, 1, 32'h80);
    chk("redir_stall_pc", imem_addr, 32'h80);
    chk("redir_stall_valid", {31'd0, ifid_valid}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("midrst_pc", imem_addr, 32'd0);
    chk("midrst_cnt", fetch_count, 32'd0);
    step(0, 0, 0, 0);
    chk("restart_ifid_pc", ifid_pc, 32'd0);
    chk("restart_instr", ifid_instr, 32'h0050_0093);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom);
    rst_w = 1;
    @(posedge clk); #1;
    chk("wrap_rst", w_addr, 32'hFFFF_FFF8);
    rst_w = 0;
    @(posedge clk); #1;
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    chk("wrap_ifid1", w_pc, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_addr2", w_addr, 32'h0000_0000);
    chk("wrap_ifid2", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_pc4, 32'h0000_0000);
    chk("wrap_instr", w_instr, mem[63]);
    chk("wrap_cnt", w_cnt, 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pl_if_stage.md
Name: pl_if_stage

Overview:
Instruction-fetch stage of the pipelined CPU, sitting directly upstream of the decode stage inside the PLCPU core.
- Owns the PC register and drives the instruction-memory address.
- Captures the combinationally read instruction into the IF/ID pipeline register.
- Handles load-use stalls from hazard detection and branch/jump redirects from EX.
- Exposes a fetch counter for debug and trace benches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID for bubbles (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  synchronous reset, active-high (asserted = 1)
stall  input  1  hazard unit request: hold PC and IF/ID
redirect  input  1  EX-stage taken branch/jump: load new PC, squash IF/ID
redirect_pc  input  32  target byte address for redirect
imem_addr  output  32  byte address to instruction memory (equals PC)
imem_rdata  input  32  instruction word, combinational read of imem_addr
ifid_valid  output  1  IF/ID holds a real fetched instruction
ifid_pc  output  32  PC of instruction in IF/ID
ifid_pc4  output  32  ifid_pc + 4
ifid_instr  output  32  instruction in IF/ID
fetch_count  output  32  number of valid instructions latched into IF/ID since reset

Behaviour:
- imem_addr = PC, purely combinational. Memory read latency is 0 cycles: imem_rdata is valid in the same cycle.
- Reset, when rstn=1 at a rising edge, takes priority over everything. Resulting values:
  - PC = RESET_PC
  - ifid_valid = 0, ifid_pc = 0, ifid_pc4 = 4, ifid_instr = NOP_INSTR
  - fetch_count = 0
- Per-edge priority when not in reset: redirect > stall > normal.
- Normal (redirect=0, stall=0):
  - ifid_pc <= PC, ifid_pc4 <= PC+4, ifid_instr <= imem_rdata, ifid_valid <= 1
  - PC <= PC+4
  - fetch_count <= fetch_count+1
- Stall (stall=1, redirect=0):
  - PC, all ifid_* and fetch_count hold their values.
  - Stall may persist any number of cycles. Fetch resumes on the first edge with stall=0, with no instruction lost or duplicated.
- Redirect (redirect=1, stall ignored):
  - PC <= {redirect_pc[31:2], 2'b00}; the low two bits are always cleared.
  - IF/ID becomes a bubble: ifid_valid <= 0, ifid_instr <= NOP_INSTR. ifid_pc and ifid_pc4 hold their previous values.
  - fetch_count holds.
  - The instruction fetched in the redirect cycle is discarded.
- Fetch latency: the instruction at a target address appears in IF/ID one edge after the PC holds that address. A redirect therefore costs exactly one bubble at IF/ID; EX squashes the ID-stage instruction itself.
- Arithmetic: PC+4 and ifid_pc4 are 32-bit modulo. PC 32'hFFFF_FFFC wraps to 32'h0000_0000. fetch_count wraps from 32'hFFFF_FFFF to 0.
- stall and redirect are sampled only at rising edges; glitches between edges have no effect.
- Reset mid-operation, including during a stall or redirect cycle, yields exactly the reset values above on that edge. The first fetch from RESET_PC occurs on the first edge after rstn returns to 0.
- No X propagation: every output has a defined value from the first reset edge onward.

Test Plan:
1. Reset then sequential run: RESET_PC=0, memory words 0x00500093, 0x00100113, 0x002081B3. Release reset → imem_addr 0, 4, 8, 12 on consecutive cycles; ifid_instr follows one edge later (0x00500093, 0x00100113, 0x002081B3); ifid_valid=1 from the first post-reset edge; fetch_count=3 after three edges.
2. Stall: with PC=8, assert stall for 2 cycles → PC stays 8, ifid_pc stays 4, fetch_count frozen. Deassert → next edge ifid_pc=8, PC=12, no duplicate or skipped instruction.
3. Redirect: with PC=12, pulse redirect with redirect_pc=0x40 → next edge PC=0x40, ifid_valid=0, ifid_instr=0x00000013. Following edge ifid_pc=0x40, ifid_valid=1. Misaligned redirect_pc=0x43 → PC=0x40.
4. Redirect and stall in the same cycle: redirect=1, stall=1, redirect_pc=0x80 → PC=0x80 and IF/ID bubble, i.e. redirect wins.
5. Reset mid-run: after 5 fetches, assert rstn=1 for one edge during an active stall → PC=RESET_PC, ifid_valid=0, fetch_count=0. Fetch restarts from RESET_PC after release.
6. Wrap-around: RESET_PC=32'hFFFF_FFF8 with no stalls → PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; when ifid_pc=FFFF_FFFC, ifid_pc4=0000_0000.
